vga_sync: RTL and testbench



---
 rtl/vga_sync.sv | 87 ++++++++
 tb/tb_vga_sync.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// 640x480@60 VGA raster timing generator: hs/vs, draw qualifier and visible (x,y).
// Define VGA_SYNC_PIXDIV2_EN to tick the raster every second clk (50 MHz clk -> 25 MHz raster).
module vga_sync #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       draw,
    output logic       hs,
    output logic       vs,
    output logic [9:0] x,
    output logic [8:0] y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       tick;
    logic       active;
    logic       hsync_on;
    logic       vsync_on;

`ifdef VGA_SYNC_PIXDIV2_EN
    // Phase starts at 0, so the first tick lands on the second edge after release.
    logic phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) phase <= 1'b0;
        else      phase <= ~phase;
    end

    assign tick = phase;
`else
    assign tick = 1'b1;
`endif

    assign active   = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign hsync_on = (hcnt >= HS_START) && (hcnt < HS_END);
    assign vsync_on = (vcnt >= VS_START) && (vcnt < VS_END);

    // Outputs are decoded from the pre-increment counters, so they lag the counters by one tick.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments keep every register reading the pre-edge counter values.
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
            draw <= 1'b0;
            hs   <= ~HS_POL;
            vs   <= ~VS_POL;
            x    <= '0;
            y    <= '0;
        end else if (tick) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
            draw <= active;
            hs   <= hsync_on ? HS_POL : ~HS_POL;
            vs   <= vsync_on ? VS_POL : ~VS_POL;
            x    <= active ? hcnt : '0;
            y    <= active ? vcnt[8:0] : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: a full-size instance for line timing and a
// short-frame instance so vertical sync and frame wrap fit in a short run.
module tb_vga_sync;

`ifdef VGA_SYNC_PIXDIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic       d_draw, d_hs, d_vs;
    logic [9:0] d_x;
    logic [8:0] d_y;
    logic       s_draw, s_hs, s_vs;
    logic [9:0] s_x;
    logic [8:0] s_y;

    vga_sync u_dflt (
        .clk (clk),
        .rst (rst),
        .draw(d_draw),
        .hs  (d_hs),
        .vs  (d_vs),
        .x   (d_x),
        .y   (d_y)
    );

    // 10-line frame: 4 visible, 1 front porch, 2 sync, 3 back porch.
    vga_sync #(
        .V_ACTIVE(4),
        .V_FP    (1),
        .V_SYNC  (2),
        .V_BP    (3)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .draw(s_draw),
        .hs  (s_hs),
        .vs  (s_vs),
        .x   (s_x),
        .y   (s_y)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {draw,hs,vs,x,y} after the k-th edge since reset release.
    function automatic logic [21:0] expect_vec(int k, int vtot, int vact, int vfp, int vsy);
        int t, s, hc, vc;
        logic d, h, v;
        logic [9:0] xx;
        logic [8:0] yy;
        t = k / DIV;
        if (t == 0) return {1'b0, 1'b1, 1'b1, 10'd0, 9'd0};
        s  = t - 1;
        hc = s % 800;
        vc = (s / 800) % vtot;
        d  = (hc < 640) && (vc < vact);
        h  = !((hc >= 656) && (hc < 752));
        v  = !((vc >= vact + vfp) && (vc < vact + vfp + vsy));
        xx = d ? 10'(hc) : 10'd0;
        yy = d ? 9'(vc) : 9'd0;
        return {d, h, v, xx, yy};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_draw"}, 32'(d_draw), 32'd0);
        check({tag, "_x"}, 32'(d_x), 32'd0);
        check({tag, "_y"}, 32'(d_y), 32'd0);
        check({tag, "_hs"}, 32'(d_hs), 32'd1);
        check({tag, "_vs"}, 32'(d_vs), 32'd1);
        check({tag, "_small"}, 32'({s_draw, s_hs, s_vs, s_x, s_y}), 32'({1'b0, 1'b1, 1'b1, 10'd0, 9'd0}));
    endtask

    task automatic run(input int n, input bit meas);
        logic pd = 1'b0, ph = 1'b1, pv = 1'b1;
        int rise_k = 0, fall_k = 0, hs_fall_k = 0, vs_fall_k = 0;
        bit per_done = 0, len_done = 0, hsd_done = 0, hsl_done = 0, vsp_done = 0, vsl_done = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            check("dflt_vec", 32'({d_draw, d_hs, d_vs, d_x, d_y}), 32'(expect_vec(k, 525, 480, 10, 2)));
            check("small_vec", 32'({s_draw, s_hs, s_vs, s_x, s_y}), 32'(expect_vec(k, 10, 4, 1, 2)));
            if (k == DIV) check("first_pixel", 32'({d_draw, d_x, d_y}), 32'({1'b1, 10'd0, 9'd0}));
            if (!meas) continue;
            if (k == DIV * 640)  check("last_x_line0", 32'({d_draw, d_x, d_y}), 32'({1'b1, 10'd639, 9'd0}));
            if (k == DIV * 701)  check("hblank_zero", 32'({d_draw, d_x, d_y}), 32'({1'b0, 10'd0, 9'd0}));
            if (k == DIV * 3040) check("small_last_vis", 32'({s_draw, s_x, s_y}), 32'({1'b1, 10'd639, 9'd3}));
            if (k == DIV * 4101) check("small_vblank", 32'({s_draw, s_x, s_y}), 32'({1'b0, 10'd0, 9'd0}));
            if (k == DIV * 8001) check("small_wrap", 32'({s_draw, s_x, s_y}), 32'({1'b1, 10'd0, 9'd0}));
            if (!pd && d_draw) begin
                if (rise_k > 0 && !per_done) begin
                    check("line_period", 32'(k - rise_k), 32'(800 * DIV));
                    per_done = 1;
                end
                rise_k = k;
            end
            if (pd && !d_draw) begin
                if (!len_done) check("draw_len", 32'(k - rise_k), 32'(640 * DIV));
                len_done = 1;
                fall_k = k;
            end
            if (ph && !d_hs) begin
                if (!hsd_done) check("hs_delay", 32'(k - fall_k), 32'(16 * DIV));
                hsd_done = 1;
                hs_fall_k = k;
            end
            if (!ph && d_hs && hsd_done && !hsl_done) begin
                check("hs_len", 32'(k - hs_fall_k), 32'(96 * DIV));
                hsl_done = 1;
            end
            if (pv && !s_vs) begin
                if (vs_fall_k > 0 && !vsp_done) begin
                    check("frame_period", 32'(k - vs_fall_k), 32'(8000 * DIV));
                    vsp_done = 1;
                end
                vs_fall_k = k;
            end
            if (!pv && s_vs && vs_fall_k > 0 && !vsl_done) begin
                check("vs_len", 32'(k - vs_fall_k), 32'(1600 * DIV));
                vsl_done = 1;
            end
            pd = d_draw;
            ph = d_hs;
            pv = s_vs;
        end
        if (meas)
            check("timing_seen", 32'({per_done, len_done, hsd_done, hsl_done, vsp_done, vsl_done}), 32'h3f);
    endtask

    initial begin
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_reset_values("rst_hold");

        @(negedge clk) rst = 1'b1;
        run(DIV * 16100, 1'b1);

        // Assert reset between edges while a line is being drawn.
        @(posedge clk);
        #2;
        check("mid_pre_draw", 32'(d_draw), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_reset_values("rst_async");

        @(negedge clk) rst = 1'b1;
        run(DIV * 900, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
